crc_frame_ctrl: RTL and testbench

CRC_FRAME_CTRL -- requirements
Module: crc_frame_ctrl

---
 rtl/crc_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_crc_frame_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: serialises a frame of data words MSB first and appends the
// frame CRC (MSB-first LFSR, preset at frame start) as trailing bits.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no frame in progress, ready for the first word
// SHIFT | data word leaving on ser_out, LFSR absorbing each bit
// WAIT  | between words of a frame, ready for the next word, LFSR held
// CRC   | LFSR contents leaving on ser_out, zero-filled, no feedback
// FIN   | one-cycle done pulse, then back to IDLE
//
// All outputs are registered.  They are loaded from the next-state values
// so that each output describes the state the FSM is in during that cycle
// (e.g. the first data bit is visible the cycle after acceptance).

module crc_frame_ctrl #(
    parameter int                DATA_W = 8,
    parameter int                CRC_W  = 8,
    parameter logic [CRC_W-1:0]  POLY   = 8'h07,
    parameter logic [CRC_W-1:0]  SEED   = 8'h00
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic [CRC_W-1:0]  crc_out,
    output logic              busy,
    output logic              done
);

    // One counter serves both the data phase and the CRC phase.
    localparam int CNT_MAX = (DATA_W > CRC_W) ? DATA_W : CRC_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DATA_END = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CRC_END  = CNT_W'(CRC_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_WAIT  = 3'd2,
        S_CRC   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [CRC_W-1:0]    lfsr, lfsr_nxt;
    logic [DATA_W-1:0]   shift_reg, shift_nxt;
    logic                last_flag, last_nxt;
    logic [CNT_W-1:0]    bit_cnt, cnt_nxt;
    logic [CRC_W-1:0]    crc_nxt;
    logic                ser_out_nxt;
    logic                ser_valid_nxt;
    logic                accept;
    logic                fb;

    // in_ready is the registered acceptance qualifier, so nothing is taken
    // on the first edge after reset release.
    assign accept = in_valid && in_ready;
    assign fb     = shift_reg[DATA_W-1] ^ lfsr[CRC_W-1];

    // Next-state and datapath update for the frame sequencer.
    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        shift_nxt = shift_reg;
        last_nxt  = last_flag;
        cnt_nxt   = bit_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    lfsr_nxt  = SEED;
                    shift_nxt = in_data;
                    last_nxt  = in_last;
                    cnt_nxt   = '0;
                    state_nxt = S_SHIFT;
                end
            end
            S_WAIT: begin
                if (accept) begin
                    shift_nxt = in_data;
                    last_nxt  = in_last;
                    cnt_nxt   = '0;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                lfsr_nxt  = (lfsr << 1) ^ (fb ? POLY : '0);
                shift_nxt = shift_reg << 1;
                if (bit_cnt == DATA_END) begin
                    cnt_nxt   = '0;
                    state_nxt = last_flag ? S_CRC : S_WAIT;
                end else begin
                    cnt_nxt = bit_cnt + 1'b1;
                end
            end
            S_CRC: begin
                lfsr_nxt = lfsr << 1;
                if (bit_cnt == CRC_END) begin
                    cnt_nxt   = '0;
                    state_nxt = S_FIN;
                end else begin
                    cnt_nxt = bit_cnt + 1'b1;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        ser_valid_nxt = 1'b0;
        ser_out_nxt   = 1'b0;
        crc_nxt       = crc_out;
        if (state_nxt == S_SHIFT) begin
            ser_valid_nxt = 1'b1;
            ser_out_nxt   = shift_nxt[DATA_W-1];
        end else if (state_nxt == S_CRC) begin
            ser_valid_nxt = 1'b1;
            ser_out_nxt   = lfsr_nxt[CRC_W-1];
        end
        if ((state_nxt == S_CRC) && (state != S_CRC)) begin
            crc_nxt = lfsr_nxt;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            lfsr      <= SEED;
            shift_reg <= '0;
            last_flag <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            lfsr      <= lfsr_nxt;
            shift_reg <= shift_nxt;
            last_flag <= last_nxt;
            bit_cnt   <= cnt_nxt;
        end
    end

    // Registered outputs; crc_out holds its value until the next capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready  <= 1'b0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            crc_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == S_IDLE) || (state_nxt == S_WAIT);
            ser_out   <= ser_out_nxt;
            ser_valid <= ser_valid_nxt;
            crc_out   <= crc_nxt;
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_FIN);
        end
    end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Bench for crc_frame_ctrl: directed frames plus randomized multi-word frames,
// checked against a polynomial long-division CRC model and frame timing rules.

module tb_crc_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       ser_out;
    logic       ser_valid;
    logic [7:0] crc_out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] fw[$];
    int         gap_before[$];
    bit         junk_en = 1'b1;
    logic [7:0] crc_a, crc_b;

    crc_frame_ctrl #(.DATA_W(8), .CRC_W(8), .POLY(8'h07), .SEED(8'h00)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .crc_out   (crc_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Remainder of (message * x^8) divided by x^8+x^2+x+1, zero preset.
    function automatic logic [7:0] ref_crc();
        logic [8:0] r;
        logic [7:0] w;
        r = '0;
        foreach (fw[k]) begin
            w = fw[k];
            for (int b = 7; b >= 0; b--) begin
                r = {r[7:0], w[b]};
                if (r[8]) r = r ^ 9'h107;
            end
        end
        for (int b = 0; b < 8; b++) begin
            r = {r[7:0], 1'b0};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    task automatic set_frame(input int n);
        fw.delete();
        gap_before.delete();
        for (int i = 0; i < n; i++) begin
            fw.push_back(8'($urandom));
            gap_before.push_back(0);
        end
    endtask

    // Drives one frame (gaps only in WAIT, junk while not ready) and checks
    // serial stream, CRC, busy length, WAIT cycles and done pulse.
    task automatic run_frame(input string name, output logic [7:0] got_crc);
        int n, idx, gap, cyc, busy_cyc, wait_cyc, done_cnt, bad_idle, total_gap, bit_err;
        bit fin;
        bit obs[$];
        bit exp_q[$];
        logic [7:0] exp_crc, w;
        n = fw.size();
        idx = 0; gap = 0; cyc = 0; busy_cyc = 0; wait_cyc = 0; done_cnt = 0;
        bad_idle = 0; total_gap = 0; bit_err = 0; fin = 1'b0;
        exp_crc = ref_crc();
        foreach (fw[k]) begin
            w = fw[k];
            for (int b = 7; b >= 0; b--) exp_q.push_back(w[b]);
        end
        for (int b = 7; b >= 0; b--) exp_q.push_back(exp_crc[b]);

        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (ser_valid) obs.push_back(ser_out);
            else if (ser_out) bad_idle++;
            if (busy) busy_cyc++;
            if (busy && in_ready) wait_cyc++;
            if (done) done_cnt++;
            if (done) begin
                fin = 1'b1;
                in_valid = 1'b0;
                in_last  = 1'b0;
            end else if (in_ready && idx < n) begin
                if (gap > 0) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    in_last  = 1'($urandom);
                    gap--;
                end else begin
                    in_valid = 1'b1;
                    in_data  = fw[idx];
                    in_last  = (idx == n - 1);
                    idx++;
                    if (idx < n) begin
                        gap = gap_before[idx];
                        total_gap += gap;
                    end
                end
            end else if (!in_ready && junk_en) begin
                in_valid = 1'($urandom);
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
        end
        if (!fin) chk({name, "_timeout"}, 0, 1);

        chk({name, "_bitcount"}, obs.size(), 8 * n + 8);
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            if (obs[i] != exp_q[i]) bit_err++;
        chk({name, "_bit_errors"}, bit_err, 0);
        chk({name, "_crc_out"}, crc_out, exp_crc);
        chk({name, "_busy_cycles"}, busy_cyc, 8 * n + 9 + (n - 1) + total_gap);
        chk({name, "_wait_cycles"}, wait_cyc, (n - 1) + total_gap);
        chk({name, "_done_pulses"}, done_cnt, 1);
        chk({name, "_ser_out_idle_zero"}, bad_idle, 0);
        got_crc = crc_out;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_in_ready"},  in_ready,  0);
        chk({name, "_ser_out"},   ser_out,   0);
        chk({name, "_ser_valid"}, ser_valid, 0);
        chk({name, "_busy"},      busy,      0);
        chk({name, "_done"},      done,      0);
        chk({name, "_crc_out"},   crc_out,   0);
    endtask

    initial begin : main
        int vcount, cyc, done_seen;
        string s;

        // Reset state and first in_ready after release.
        #2;
        check_all_zero("reset");
        #10;
        reset_n = 1'b1;
        #1;
        chk("ready_before_first_edge", in_ready, 0);
        @(negedge clk);
        chk("ready_after_first_edge", in_ready, 1);

        // Single word 0x01.
        fw = '{8'h01};
        gap_before = '{0};
        run_frame("w01", crc_a);
        chk("w01_crc_const", crc_a, 8'h07);
        repeat (3) @(negedge clk);
        chk("w01_crc_hold", crc_out, 8'h07);

        // Single word 0x00.
        fw = '{8'h00};
        gap_before = '{0};
        run_frame("w00", crc_a);
        chk("w00_crc_const", crc_a, 8'h00);

        // "123456789" with in_valid held, then with a 5-cycle gap in WAIT.
        fw = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        gap_before = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_frame("check", crc_a);
        chk("check_crc_const", crc_a, 8'hF4);
        gap_before[4] = 5;
        run_frame("check_gap", crc_b);
        chk("check_gap_same_crc", crc_b, crc_a);

        // Reset asserted at CRC bit 4 of a 0x01 frame.
        @(negedge clk);
        while (!in_ready) @(negedge clk);
        in_valid = 1'b1; in_data = 8'h01; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        vcount = ser_valid ? 1 : 0;
        cyc = 0;
        while (vcount < 13 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (ser_valid) vcount++;
        end
        chk("rst_reach_crc_bit4", vcount, 13);
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("midcrc_reset");
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        #1;
        reset_n = 1'b1;
        #1;
        chk("rst2_ready_before_edge", in_ready, 0);
        repeat (2) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("rst2_no_done", done_seen, 0);
        chk("rst2_ready", in_ready, 1);
        fw = '{8'h01};
        gap_before = '{0};
        run_frame("post_rst", crc_a);
        chk("post_rst_crc_const", crc_a, 8'h07);

        // Randomized frames with random WAIT gaps and junk during SHIFT/CRC.
        for (int f = 0; f < 25; f++) begin
            set_frame(int'($urandom_range(1, 5)));
            for (int i = 1; i < fw.size(); i++) gap_before[i] = int'($urandom_range(0, 3));
            s = $sformatf("rand%0d", f);
            run_frame(s, crc_a);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
